// File: rtl/mips_mem_arbiter_if.sv
// rtl/mips_mem_arbiter_if.sv - IF/DM requester and memory-side bus of the mips_mem_arbiter
interface mips_mem_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          flush;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_done;
    logic [DW-1:0] dm_rdata;
    logic          err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, flush, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_done, dm_rdata, err,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, flush, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_done, dm_rdata, err,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - single-port memory arbiter for IF fetch and DM load/store
// Optional IF anti-starvation counter enabled by defining MIPS_ARB_STARVE_EN.
module mips_mem_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int TIMEOUT    = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    mips_mem_arbiter_if.slave bus
);
    typedef enum logic {IDLE, ACCESS} state_t;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state, state_nx;
    logic          owner_dm, lat_we, flushed;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [TW-1:0] tmo_cnt;
    logic          if_rvalid_q, dm_done_q, err_q;
    logic [DW-1:0] if_rdata_q, dm_rdata_q;
    logic          grant_if, grant_dm, ack_done, tmo_done, if_cancel, starve_hit;

`ifdef MIPS_ARB_STARVE_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_cnt;

    assign starve_hit = (starve_cnt == SW'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt <= '0;
        else if (grant_if)
            starve_cnt <= '0;
        else if (grant_dm && bus.if_req && !starve_hit)
            starve_cnt <= starve_cnt + 1'b1;
    end
`else
    logic [31:0] starve_unused;
    assign starve_hit    = 1'b0;
    assign starve_unused = STARVE_MAX;
`endif

    always_comb begin
        state_nx = state;
        grant_if = 1'b0;
        grant_dm = 1'b0;
        ack_done = 1'b0;
        tmo_done = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    if (starve_hit && bus.if_req && !bus.flush) grant_if = 1'b1;
                    else if (bus.dm_req)                         grant_dm = 1'b1;
                    else if (bus.if_req && !bus.flush)           grant_if = 1'b1;
                    if (grant_if || grant_dm) state_nx = ACCESS;
                end
            end
            ACCESS: begin
                // an ack in the expiry cycle wins over the timeout
                if (bus.mem_ack)                          ack_done = 1'b1;
                else if (tmo_cnt == TW'(TIMEOUT - 1))     tmo_done = 1'b1;
                if (ack_done || tmo_done) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign if_cancel = flushed | bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner_dm    <= 1'b0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            tmo_cnt     <= '0;
            flushed     <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_done_q   <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state       <= state_nx;
            if_rvalid_q <= 1'b0;
            dm_done_q   <= 1'b0;
            err_q       <= 1'b0;
            if (grant_if || grant_dm) begin
                owner_dm  <= grant_dm;
                lat_we    <= grant_dm & bus.dm_we;
                lat_addr  <= grant_dm ? bus.dm_addr : bus.if_addr;
                lat_wdata <= bus.dm_wdata;
                tmo_cnt   <= '0;
                flushed   <= 1'b0;
            end
            if (state == ACCESS) begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (!owner_dm && bus.flush) flushed <= 1'b1;
            end
            if (ack_done || tmo_done) begin
                if (owner_dm) begin
                    dm_done_q <= 1'b1;
                    err_q     <= tmo_done;
                    if (ack_done && !lat_we) dm_rdata_q <= bus.mem_rdata;
                end else if (!if_cancel) begin
                    if_rvalid_q <= 1'b1;
                    err_q       <= tmo_done;
                    if (ack_done) if_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.if_gnt    = grant_if;
    assign bus.dm_gnt    = grant_dm;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_done   = dm_done_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.err       = err_q;
    assign bus.mem_req   = (state == ACCESS);
    assign bus.mem_we    = (state == ACCESS) & lat_we;
    assign bus.mem_addr  = lat_addr;
    assign bus.mem_wdata = lat_wdata;
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb/tb_mips_mem_arbiter.sv - self-checking bench for mips_mem_arbiter with a memory and transaction model
module tb_mips_mem_arbiter;
    localparam int AW = 10, DW = 32, TIMEOUT = 16, STARVE_MAX = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_mem_arbiter_if #(.AW(AW), .DW(DW)) ifc ();

    mips_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst), .bus(ifc)
    );

    int n_vec = 0, n_err = 0;

    // transaction model: one outstanding access, memory array, expected registered outputs
    logic [DW-1:0] mem_arr [1024];
    logic          busy, m_dm, m_we, m_fl;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    int            age, dly, force_dly, starve;
    logic          e_ifv, e_dmd, e_err;
    logic [DW-1:0] e_ifrd, e_dmrd;
    logic          g_dm, g_if;
    logic          act_dm_gnt, act_if_gnt, act_mem_req, act_dm_done, act_err;

    typedef struct {
        logic dq, iq, fl;
        logic eg_dm, eg_if;
    } arb_vec_t;
    arb_vec_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic dq, input logic dwe, input logic [AW-1:0] da,
                         input logic [DW-1:0] dd, input logic iq, input logic [AW-1:0] ia,
                         input logic fl);
        logic ack, pick_if;
        logic [DW-1:0] rd;
        rst = r;
        ifc.dm_req = dq; ifc.dm_we = dwe; ifc.dm_addr = da; ifc.dm_wdata = dd;
        ifc.if_req = iq; ifc.if_addr = ia; ifc.flush = fl;
        ack = busy && !r && (age == dly);
        rd  = ack ? mem_arr[m_addr] : $urandom;
        ifc.mem_ack = ack; ifc.mem_rdata = rd;
        pick_if = 1'b0;
`ifdef MIPS_ARB_STARVE_EN
        pick_if = (starve == STARVE_MAX) && iq && !fl;
`endif
        g_dm = 1'b0; g_if = 1'b0;
        if (!r && !busy) begin
            if (pick_if)          g_if = 1'b1;
            else if (dq)          g_dm = 1'b1;
            else if (iq && !fl)   g_if = 1'b1;
        end
        #1;
        act_dm_gnt = ifc.dm_gnt; act_if_gnt = ifc.if_gnt; act_mem_req = ifc.mem_req;
        act_dm_done = ifc.dm_done; act_err = ifc.err;
        chk("dm_gnt", ifc.dm_gnt, g_dm);
        chk("if_gnt", ifc.if_gnt, g_if);
        chk("if_rvalid", ifc.if_rvalid, e_ifv);
        chk("dm_done", ifc.dm_done, e_dmd);
        chk("err", ifc.err, e_err);
        chk("if_rdata", ifc.if_rdata, e_ifrd);
        chk("dm_rdata", ifc.dm_rdata, e_dmrd);
        chk("mem_req", ifc.mem_req, busy);
        chk("mem_we", ifc.mem_we, busy & m_we);
        if (busy) chk("mem_addr", ifc.mem_addr, m_addr);
        if (busy && m_we) chk("mem_wdata", ifc.mem_wdata, m_wdata);
        if (r) begin
            busy = 0; e_ifv = 0; e_dmd = 0; e_err = 0; e_ifrd = '0; e_dmrd = '0; starve = 0;
        end else begin
            e_ifv = 0; e_dmd = 0; e_err = 0;
            if (busy) begin
                if (!m_dm) m_fl = m_fl | fl;
                if (ack) begin
                    busy = 0;
                    if (m_we) mem_arr[m_addr] = m_wdata;
                    if (m_dm) begin
                        e_dmd = 1;
                        if (!m_we) e_dmrd = rd;
                    end else if (!m_fl) begin
                        e_ifv = 1; e_ifrd = rd;
                    end
                end else if (age == TIMEOUT - 1) begin
                    busy = 0;
                    if (m_dm) begin e_dmd = 1; e_err = 1; end
                    else if (!m_fl) begin e_ifv = 1; e_err = 1; end
                end else begin
                    age++;
                end
            end
            if (g_dm || g_if) begin
                busy = 1; age = 0; m_fl = 0; m_dm = g_dm;
                m_we = g_dm & dwe; m_addr = g_dm ? da : ia; m_wdata = dd;
                dly = (force_dly >= 0) ? force_dly : int'($urandom_range(0, TIMEOUT + 1));
                if (g_if) starve = 0;
                else if (iq && starve < STARVE_MAX) starve++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input logic r);
        cycle(r, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic drain();
        repeat (TIMEOUT + 3) idle(1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic dq_r, iq_r;
        int nreq, got, errs;
        logic [2:0] order;
        int ng;

        tbl[0] = '{0, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 0, 1, 0};
        tbl[2] = '{0, 1, 0, 0, 1};
        tbl[3] = '{1, 1, 0, 1, 0};
        tbl[4] = '{0, 1, 1, 0, 0};
        tbl[5] = '{1, 1, 1, 1, 0};
        tbl[6] = '{1, 0, 1, 1, 0};
        for (int i = 0; i < 1024; i++) mem_arr[i] = $urandom;
        busy = 0; m_dm = 0; m_we = 0; m_fl = 0; m_addr = '0; m_wdata = '0;
        age = 0; dly = 0; force_dly = -1; starve = 0;
        e_ifv = 0; e_dmd = 0; e_err = 0; e_ifrd = '0; e_dmrd = '0;

        rst = 1'b1;
        ifc.dm_req = 0; ifc.dm_we = 0; ifc.dm_addr = '0; ifc.dm_wdata = '0;
        ifc.if_req = 0; ifc.if_addr = '0; ifc.flush = 0; ifc.mem_ack = 0; ifc.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        idle(1'b1);
        chk("rst_if_gnt", ifc.if_gnt, 0);   chk("rst_dm_gnt", ifc.dm_gnt, 0);
        chk("rst_mem_req", ifc.mem_req, 0); chk("rst_mem_we", ifc.mem_we, 0);
        chk("rst_mem_addr", ifc.mem_addr, 0); chk("rst_mem_wdata", ifc.mem_wdata, 0);
        chk("rst_if_rdata", ifc.if_rdata, 0); chk("rst_dm_rdata", ifc.dm_rdata, 0);
        chk("rst_pulses", {ifc.if_rvalid, ifc.dm_done, ifc.err}, 0);

        // arbitration table in IDLE; each vector is followed by a reset to return to IDLE
        force_dly = 99;
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, tbl[i].dq, 1'b0, 10'h011, '0, tbl[i].iq, 10'h022, tbl[i].fl);
            chk("tbl_dm_gnt", act_dm_gnt, tbl[i].eg_dm);
            chk("tbl_if_gnt", act_if_gnt, tbl[i].eg_if);
            idle(1'b1);
        end

        // IF read with ack in the first request cycle
        mem_arr[5] = 32'h2801_0078;
        force_dly = 0;
        cycle(1'b0, 0, 0, '0, '0, 1, 10'h005, 0);
        chk("t1_if_gnt", act_if_gnt, 1);
        chk("t1_mem_req", ifc.mem_req, 1);
        chk("t1_mem_addr", ifc.mem_addr, 10'h005);
        idle(1'b0);
        chk("t1_rvalid", ifc.if_rvalid, 1);
        chk("t1_rdata", ifc.if_rdata, 32'h2801_0078);
        drain();

        // DM load to set dm_rdata, then store with a 3-cycle ack delay
        mem_arr[10'h010] = 32'hdead_beef;
        force_dly = 1;
        cycle(1'b0, 1, 0, 10'h010, '0, 0, '0, 0);
        drain();
        chk("t2_load_rdata", ifc.dm_rdata, 32'hdead_beef);
        force_dly = 3;
        cycle(1'b0, 1, 1, 10'h079, 32'h82, 0, '0, 0);
        for (int k = 0; k < 4; k++) begin
            chk("t2_mem_we", ifc.mem_we, 1);
            chk("t2_mem_addr", ifc.mem_addr, 10'h079);
            chk("t2_mem_wdata", ifc.mem_wdata, 32'h82);
            idle(1'b0);
        end
        chk("t2_dm_done", ifc.dm_done, 1);
        chk("t2_dm_rdata", ifc.dm_rdata, 32'hdead_beef);
        chk("t2_mem_req_drop", ifc.mem_req, 0);
        drain();

        // both request: DM first, IF granted in the dm_done cycle
        mem_arr[10'h030] = 32'h1111_2222;
        force_dly = 0;
        cycle(1'b0, 1, 1, 10'h020, 32'h55, 1, 10'h030, 0);
        chk("t3_dm_first", {act_dm_gnt, act_if_gnt}, 2'b10);
        cycle(1'b0, 0, 0, '0, '0, 1, 10'h030, 0);
        cycle(1'b0, 0, 0, '0, '0, 1, 10'h030, 0);
        chk("t3_done_cycle", {act_dm_done, act_if_gnt}, 2'b11);
        drain();

`ifdef MIPS_ARB_STARVE_EN
        idle(1'b1);
        order = '0; ng = 0;
        for (int k = 0; k < 20 && ng < 3; k++) begin
            cycle(1'b0, 1, 1, 10'h040, 32'h7, 1, 10'h041, 0);
            if (act_dm_gnt || act_if_gnt) begin
                order[ng] = act_if_gnt;
                ng++;
            end
        end
        chk("t3_starve_order", {29'd0, order}, 32'b100);
        drain();
`endif

        // flush while an IF access is in flight, then flush in IDLE
        force_dly = 2;
        cycle(1'b0, 0, 0, '0, '0, 1, 10'h050, 0);
        cycle(1'b0, 0, 0, '0, '0, 0, '0, 1);
        chk("t4_mem_req_kept", act_mem_req, 1);
        idle(1'b0);
        idle(1'b0);
        chk("t4_no_rvalid", ifc.if_rvalid, 0);
        chk("t4_rdata_kept", ifc.if_rdata, 32'h1111_2222);
        drain();
        force_dly = 0;
        cycle(1'b0, 0, 0, '0, '0, 1, 10'h051, 1);
        chk("t4_idle_flush_blocks", act_if_gnt, 0);
        cycle(1'b0, 0, 0, '0, '0, 1, 10'h051, 0);
        drain();

        // no ack at all: timeout
        force_dly = 99;
        cycle(1'b0, 1, 0, 10'h060, '0, 0, '0, 0);
        nreq = 0; got = 0; errs = 0;
        for (int k = 0; k < 40; k++) begin
            idle(1'b0);
            if (act_mem_req) nreq++;
            if (act_dm_done) begin
                got = 1; errs = act_err;
                break;
            end
        end
        chk("t5_req_cycles", nreq, TIMEOUT);
        chk("t5_done_err", {got[0], errs[0]}, 2'b11);
        chk("t5_rdata_kept", ifc.dm_rdata, 32'hdead_beef);
        drain();

        // reset two cycles into an access
        force_dly = 99;
        cycle(1'b0, 0, 0, '0, '0, 1, 10'h070, 0);
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);
        chk("t6_mem_req", ifc.mem_req, 0);
        chk("t6_outputs", {ifc.if_rvalid, ifc.dm_done, ifc.err, ifc.mem_we}, 0);
        chk("t6_rdata", ifc.if_rdata | ifc.dm_rdata, 0);
        force_dly = 0;
        cycle(1'b0, 1, 0, 10'h071, '0, 0, '0, 0);
        chk("t6_gnt_after_rst", act_dm_gnt, 1);
        drain();

        // randomized traffic against the model
        force_dly = -1;
        dq_r = 0; iq_r = 0;
        for (int i = 0; i < 3000; i++) begin
            logic r;
            if (!dq_r) dq_r = ($urandom_range(0, 3) == 0);
            if (!iq_r) iq_r = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 299) == 0);
            cycle(r, dq_r, 1'($urandom), AW'($urandom_range(0, 15)), $urandom,
                  iq_r, AW'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0));
            if (g_dm) dq_r = 1'($urandom);
            if (g_if) iq_r = 1'($urandom);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Arbitrates one single-port memory between the pipeline's instruction-fetch requester (IF, read-only) and data requester (DM, load/store).
- Sits between the pipe_MIPS32 IF/MEM stages and the unified Mem array.
- Sequences each access through a request/acknowledge handshake.
- Supports branch flush of in-flight fetches and aborts accesses with no memory response (timeout).

Parameters:
AW, 10, address width (1024-word memory)
DW, 32, data width
TIMEOUT, 16, max cycles waiting for mem_ack before abort (>=1)
STARVE_MAX, 4, consecutive DM grants tolerated while IF waits (used only with the optional feature)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held until if_gnt
if_addr  in  AW  fetch address; sampled on the if_gnt cycle
if_gnt  out  1  one-cycle grant pulse to IF
if_rvalid  out  1  one-cycle pulse; if_rdata valid
if_rdata  out  DW  fetched instruction word
flush  in  1  taken branch; cancels the outstanding or same-cycle IF access
dm_req  in  1  data request; held until dm_gnt
dm_we  in  1  1 = store, 0 = load; sampled on the dm_gnt cycle
dm_addr  in  AW  data address; sampled on the dm_gnt cycle
dm_wdata  in  DW  store data; sampled on the dm_gnt cycle
dm_gnt  out  1  one-cycle grant pulse to DM
dm_done  out  1  one-cycle pulse; load or store complete
dm_rdata  out  DW  load data
err  out  1  one-cycle pulse with if_rvalid/dm_done on timeout abort
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_ack  in  1  memory accepts/completes; may be high in the first mem_req cycle
mem_rdata  in  DW  read data; valid when mem_ack = 1

Behaviour:
Reset:
- All outputs are 0. if_rdata and dm_rdata clear to 0.
- FSM goes to IDLE. Owner, timeout and starve counters clear.
- Reset mid-access: mem_req drops at the same edge. No done/rvalid/err pulse is issued for the aborted access.

FSM states: IDLE, ACCESS.
IDLE:
- If dm_req: DM wins. If not dm_req and if_req and not flush: IF wins.
- Winner gets a one-cycle gnt. Addr, we and wdata are latched. Owner is recorded. Next state is ACCESS.
- No request: stay in IDLE.
ACCESS:
- mem_req = 1 with the latched addr/we/wdata, held stable until mem_ack is sampled high.
- On mem_ack: mem_req drops next cycle. Load data is captured from mem_rdata. The owner's done/rvalid pulses next cycle. State returns to IDLE.
- Stores leave dm_rdata unchanged.

Latency and throughput:
- Grant at cycle N. mem_req is high from N+1. With ack at N+1, done/rvalid is at N+2.
- At most one access outstanding. The next grant is possible in the cycle done/rvalid pulses (IDLE).
- gnt, done, rvalid and err are never high for both requesters at once.

Timeout:
- The counter starts at 0 on entry to ACCESS and increments each cycle without ack.
- When it reaches TIMEOUT: mem_req drops. The owner's done/rvalid pulses together with err. rdata is unchanged. State returns to IDLE.
- mem_ack in the same cycle as expiry counts as a normal completion (no err).

Flush:
- flush during an IF access: the memory access still completes (mem_req is not withdrawn), but if_rvalid and err are suppressed and if_rdata is not updated.
- flush in IDLE blocks an IF grant that cycle. A DM grant is unaffected.
- flush in the same cycle as the IF completion edge also suppresses it.

Requester behaviour: requesters may drop req after gnt. Changing address or data before gnt is legal, and the value sampled at gnt is used.

Optional Feature:
Macro: MIPS_ARB_STARVE_EN
- Defined: a counter increments on each DM grant made while if_req is high and clears on any IF grant. When the counter equals STARVE_MAX, the next IDLE arbitration with if_req high and flush low grants IF even if dm_req is high. The counter saturates at STARVE_MAX and clears on reset.
- Undefined: strict DM priority, and no counter logic is generated.

Test Plan:
1. Reset then IF read addr 0x005, mem_ack in first req cycle, mem_rdata 0x28010078 -> if_gnt at N, mem_req at N+1, if_rvalid with if_rdata 0x28010078 at N+2.
2. DM store addr 0x079 data 0x82, mem_ack delayed 3 cycles -> mem_we=1, addr/data stable 4 cycles, dm_done one cycle after ack, dm_rdata unchanged.
3. dm_req and if_req both high in IDLE (feature off) -> DM granted first, IF granted in the cycle dm_done pulses. With the feature on and STARVE_MAX=2, after 2 DM grants with IF waiting, IF is granted despite dm_req.
4. IF access in flight, flush pulses before ack -> memory access completes, no if_rvalid, if_rdata keeps its old value. flush high in IDLE with only if_req -> no grant.
5. mem_ack never asserted, TIMEOUT=16 -> mem_req drops after 16 cycles, err and dm_done pulse together, FSM back in IDLE.
6. rst asserted two cycles into ACCESS -> mem_req 0 and all outputs 0 after that edge, no completion pulses, new grant possible the first cycle after rst deasserts.
